// File: rtl/register_file_bypass_scoreboard_if.sv
// Register file bus between the decode/writeback stages and the register file.
// Groups the read ports, both write ports, the reserve strobe and the status
// outputs. Clock and reset stay as plain module ports.
//   master: pipeline side (drives addresses, write data, reserve).
//   slave : register file side (returns read data, busy flags, v0, pending count).
interface register_file_bypass_scoreboard_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] read_addr_a;
    logic [DATA_WIDTH-1:0] read_data_a;
    logic                  read_busy_a;
    logic [ADDR_WIDTH-1:0] read_addr_b;
    logic [DATA_WIDTH-1:0] read_data_b;
    logic                  read_busy_b;
    logic [ADDR_WIDTH-1:0] write_addr_c;
    logic                  write_enable_c;
    logic [DATA_WIDTH-1:0] write_data_c;
    logic [ADDR_WIDTH-1:0] write_addr_d;
    logic                  write_enable_d;
    logic [DATA_WIDTH-1:0] write_data_d;
    logic [ADDR_WIDTH-1:0] reserve_addr;
    logic                  reserve_enable;
    logic [DATA_WIDTH-1:0] register_v0;
    logic [ADDR_WIDTH:0]   pending_count;

    modport master (
        output read_addr_a, read_addr_b,
        output write_addr_c, write_enable_c, write_data_c,
        output write_addr_d, write_enable_d, write_data_d,
        output reserve_addr, reserve_enable,
        input  read_data_a, read_busy_a, read_data_b, read_busy_b,
        input  register_v0, pending_count
    );

    modport slave (
        input  read_addr_a, read_addr_b,
        input  write_addr_c, write_enable_c, write_data_c,
        input  write_addr_d, write_enable_d, write_data_d,
        input  reserve_addr, reserve_enable,
        output read_data_a, read_busy_a, read_data_b, read_busy_b,
        output register_v0, pending_count
    );
endinterface

// File: rtl/register_file_bypass_scoreboard.sv
// General-purpose register file with two combinational read ports, two write
// ports (C: ALU writeback, D: load/multicycle writeback, D wins collisions),
// optional same-cycle write-to-read bypass and a per-register pending-write
// scoreboard with population count.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : synchronous, active-high; forces combinational outputs to 0
//   rf    : register file bus (slave side), see register_file_bypass_scoreboard_if
module register_file_bypass_scoreboard #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    register_file_bypass_scoreboard_if.slave rf
);
    localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;
    localparam int unsigned V0_ADDR = 2;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      pending_q, pending_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic wr_c_qual, wr_d_qual, rsv_qual;

    // Address 0 is hardwired: writes and reserves to it never qualify.
    assign wr_c_qual = rf.write_enable_c && (rf.write_addr_c != '0);
    assign wr_d_qual = rf.write_enable_d && (rf.write_addr_d != '0);
    assign rsv_qual  = rf.reserve_enable && (rf.reserve_addr != '0);

    // Register array next state; D is applied last so it wins a collision.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_c_qual) regs_d[rf.write_addr_c] = rf.write_data_c;
        if (wr_d_qual) regs_d[rf.write_addr_d] = rf.write_data_d;
    end

    // Scoreboard next state: writes clear, then a reserve re-sets, so a new
    // reservation supersedes a writeback landing in the same cycle.
    always_comb begin
        pending_d = pending_q;
        count_d   = '0;
        if (wr_c_qual) pending_d[rf.write_addr_c] = 1'b0;
        if (wr_d_qual) pending_d[rf.write_addr_d] = 1'b0;
        if (rsv_qual)  pending_d[rf.reserve_addr] = 1'b1;
        pending_d[0] = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            count_d = count_d + CNT_W'(pending_d[i]);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    // Read port A with optional forwarding (D has priority over C).
    always_comb begin
        rf.read_data_a = '0;
        rf.read_busy_a = 1'b0;
        if (!reset && (rf.read_addr_a != '0)) begin
            rf.read_data_a = regs_q[rf.read_addr_a];
            rf.read_busy_a = pending_q[rf.read_addr_a];
            if (BYPASS) begin
                if (wr_c_qual && (rf.write_addr_c == rf.read_addr_a)) rf.read_data_a = rf.write_data_c;
                if (wr_d_qual && (rf.write_addr_d == rf.read_addr_a)) rf.read_data_a = rf.write_data_d;
            end
        end
    end

    // Read port B, same structure as port A.
    always_comb begin
        rf.read_data_b = '0;
        rf.read_busy_b = 1'b0;
        if (!reset && (rf.read_addr_b != '0)) begin
            rf.read_data_b = regs_q[rf.read_addr_b];
            rf.read_busy_b = pending_q[rf.read_addr_b];
            if (BYPASS) begin
                if (wr_c_qual && (rf.write_addr_c == rf.read_addr_b)) rf.read_data_b = rf.write_data_c;
                if (wr_d_qual && (rf.write_addr_d == rf.read_addr_b)) rf.read_data_b = rf.write_data_d;
            end
        end
    end

    assign rf.register_v0   = reset ? '0 : regs_q[V0_ADDR];
    assign rf.pending_count = count_q;
endmodule

// File: doc/register_file_bypass_scoreboard.md
Name: register_file_bypass_scoreboard

Overview:
- Parametrised successor of the CPU general-purpose register file: 2 read ports and 2 write ports (c: ALU writeback, d: load/multicycle writeback).
- Adds optional same-cycle write-to-read bypass, deterministic write-collision priority, and a per-register pending-write scoreboard for hazard detection in the Harvard pipeline.
- Sits between decode (reads, reserve) and writeback (writes).

Parameters:
- DATA_WIDTH, 32, width of each register and data port.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads return stored contents only.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high.
- register_v0  output  DATA_WIDTH  stored contents of register 2 (never bypassed).
- read_addr_a  input  ADDR_WIDTH  read port A address.
- read_data_a  output  DATA_WIDTH  read port A data (combinational).
- read_busy_a  output  1  register at read_addr_a has a pending write.
- read_addr_b  input  ADDR_WIDTH  read port B address.
- read_data_b  output  DATA_WIDTH  read port B data.
- read_busy_b  output  1  register at read_addr_b has a pending write.
- write_addr_c  input  ADDR_WIDTH  write port C address.
- write_enable_c  input  1  write port C enable.
- write_data_c  input  DATA_WIDTH  write port C data.
- write_addr_d  input  ADDR_WIDTH  write port D address.
- write_enable_d  input  1  write port D enable.
- write_data_d  input  DATA_WIDTH  write port D data.
- reserve_addr  input  ADDR_WIDTH  register to mark pending (destination of an in-flight op).
- reserve_enable  input  1  reserve strobe.
- pending_count  output  ADDR_WIDTH+1  number of registers currently pending.

Behaviour:
- Reset (synchronous): at the next posedge all registers become 0, all pending bits clear, pending_count = 0.
- While reset is high, all combinational outputs are forced to 0: read_data_*, read_busy_*, register_v0.
- Register 0:
  - Reads always return 0 and read_busy is always 0.
  - Writes and reserves to address 0 are ignored.
- Writes (posedge, reset low):
  - Port C writes write_addr_c when write_enable_c is high and its own address is nonzero.
  - Port D qualifies independently on write_enable_d and write_addr_d != 0.
  - Same nonzero address on both ports: port D data is stored.
- Reads: combinational, zero latency.
  - BYPASS=1 with read address matching an enabled nonzero write address returns that write data; if both ports match, D takes priority.
  - BYPASS=0 returns stored contents; new data is visible the cycle after the write.
- Scoreboard: one pending bit per register, updated at posedge.
  - A qualifying write on C or D clears the pending bit for its address.
  - reserve_enable with nonzero reserve_addr sets the pending bit.
  - Reserve and write to the same address in one cycle: pending ends set (the new op supersedes).
  - Reserving an already-pending register leaves it pending; the count does not double.
  - A write to a non-pending register leaves the bit clear.
- read_busy_x is the stored pending bit for read_addr_x. It is not bypassed: a write in the current cycle does not clear busy until the next cycle.
- pending_count equals the population count of the pending bits, updated in the same cycle as the bits. Maximum value is 2**ADDR_WIDTH - 1 (register 0 is never pending), so there is no overflow.
- register_v0 is the stored register 2 contents (0 during reset) and is unaffected by BYPASS.
- Reset asserted mid-operation discards all pending reservations; late writebacks after reset are ordinary writes.

Test Plan:
- Reset, then write C: r5=0xDEADBEEF. Next cycle read A=5 -> 0xDEADBEEF; read B=0 -> 0; register_v0 = 0.
- Write C r0=0x1234 and D r0=0x5678 -> reading r0 gives 0; reserve r0 -> read_busy stays 0, pending_count stays 0.
- Same cycle C r7=0x11, D r7=0x22:
  - BYPASS=1: read A=7 returns 0x22 combinationally in that cycle.
  - Next cycle stored value is 0x22.
  - BYPASS=0: in-cycle read returns the old value.
- Scoreboard sequence:
  - Reserve r9 -> read_busy_a(9)=1, pending_count=1.
  - Reserve r9 again -> count stays 1.
  - Write D r9=0xAA -> busy still 1 that cycle; next cycle busy=0, count=0.
- Reserve r3 and write C r3 in the same cycle -> r3 data updated, busy=1, count=1. Write r2=0x42 -> register_v0 = 0x42 one cycle later.
- Reserve r4, r6, r8 (count=3), then assert reset for 1 cycle -> count=0, all busy=0, all reads 0. During reset, read_data and register_v0 are forced to 0.
